fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 14 +
 rtl/program_counter.sv | 32 +++
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared state encodings and default widths for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned DefInstrWidth = 10;
  localparam int unsigned DefAddrBits   = 6;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StHalt = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Fetch address register: clear to zero, load a branch target, or step with natural wrap.
module program_counter
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DefAddrBits
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic                 i_inc,
  input  logic [ADDR_BITS-1:0] i_target,
  output logic [ADDR_BITS-1:0] o_pc
);

  logic [ADDR_BITS-1:0] r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (i_clr) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Loads a program into an external combinational-read memory, then fetches it
// sequentially with branch redirect and halt/resume.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = DefInstrWidth,
  parameter int unsigned ADDR_BITS         = DefAddrBits
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  input  logic                         run,
  input  logic                         halt_req,
  input  logic                         branch_taken,
  input  logic [ADDR_BITS-1:0]         branch_target,
  output logic [ADDR_BITS-1:0]         mem_addr,
  output logic                         mem_we,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic                         instr_valid,
  output logic [ADDR_BITS-1:0]         pc,
  output logic [1:0]                   state,
  output logic [ADDR_BITS:0]           load_count
);

  fetch_state_e                 r_state;
  logic [ADDR_BITS-1:0]         r_wr_ptr;
  logic [ADDR_BITS:0]           r_load_count;
  logic [INSTRUCTION_WIDTH-1:0] r_instr;
  logic                         r_instr_valid;

  logic                 w_accept;
  logic                 w_load_done;
  logic                 w_pc_clr;
  logic                 w_pc_load;
  logic                 w_pc_inc;
  logic [ADDR_BITS-1:0] w_pc;

  always_comb begin
    w_accept    = (r_state == StLoad) && load_valid;
    // The top address always closes the load so the write pointer never wraps.
    w_load_done = w_accept && (load_last || (r_wr_ptr == '1));
    w_pc_clr    = (r_state == StIdle) && !load_start && run;
    w_pc_load   = (r_state == StRun) && !halt_req && branch_taken;
    w_pc_inc    = (r_state == StRun) && !halt_req && !branch_taken;
  end

  program_counter #(
    .ADDR_BITS(ADDR_BITS)
  ) u_program_counter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_pc_clr),
    .i_load  (w_pc_load),
    .i_inc   (w_pc_inc),
    .i_target(branch_target),
    .o_pc    (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_wr_ptr      <= '0;
      r_load_count  <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_instr_valid <= 1'b0;
          if (load_start) begin
            r_state      <= StLoad;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
          end else if (run) begin
            r_state <= StRun;
          end
        end
        StLoad: begin
          r_instr_valid <= 1'b0;
          if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_load_count <= r_load_count + 1'b1;
          end
          if (w_load_done) begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          if (halt_req) begin
            r_state       <= StHalt;
            r_instr_valid <= 1'b0;
          end else if (branch_taken) begin
            // Drop the fall-through word; instr keeps its last valid value.
            r_instr_valid <= 1'b0;
          end else begin
            r_instr       <= mem_rdata;
            r_instr_valid <= 1'b1;
          end
        end
        StHalt: begin
          r_instr_valid <= 1'b0;
          if (load_start) begin
            r_state      <= StLoad;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
          end else if (run) begin
            r_state <= StRun;
          end
        end
        default: begin
          r_state       <= StIdle;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    load_ready  = (r_state == StLoad);
    mem_we      = w_accept;
    mem_wdata   = load_data;
    mem_addr    = (r_state == StLoad) ? r_wr_ptr : w_pc;
    instr       = r_instr;
    instr_valid = r_instr_valid;
    pc          = w_pc;
    state       = r_state;
    load_count  = r_load_count;
  end

endmodule
